regwrite_buffer: RTL and testbench

- Parametrised successor of the 16-bit register write-back stage.
- Accepts completed ALU results, queues them in a DEPTH-entry in-order retire FIFO, and drains them to the register file.
- Drain is gated by an rf_ready back-pressure signal.
- Provides generalised per-byte-lane write enables, a registered PC-redirect pulse, and a youngest-first forwarding lookup over pending writes, so decode can bypass values not yet in the register file.

---
 rtl/nqcpu_pkg.sv | 24 ++
 rtl/wb_fwd_merge.sv | 39 +++
 rtl/regwrite_buffer.sv | 89 ++++++++
 tb/tb_regwrite_buffer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/nqcpu_pkg.sv
// nqcpu_pkg: shared write-back types and the byte-lane derivation.
package nqcpu_pkg;
    function automatic int lanes_of(input int data_w);
        return data_w / 8;
    endfunction

    localparam int NQ_DATA_W = 16;
    localparam int NQ_REG_AW = 4;
    localparam int NQ_LANES  = lanes_of(NQ_DATA_W);

    typedef struct packed {
        logic [NQ_REG_AW-1:0] reg_dest;
        logic [NQ_DATA_W-1:0] data;
        logic [NQ_LANES-1:0]  be;
    } wb_entry_t;

    // be replaces reg_write[1:0]; legacy hb/lb are be[1]/be[0] at 16 bits
    typedef struct packed {
        logic [NQ_REG_AW-1:0] reg_dest;
        logic [NQ_DATA_W-1:0] result;
        logic [NQ_LANES-1:0]  be;
        logic                 setpc;
    } alu_signals;
endpackage

// File: rtl/wb_fwd_merge.sv
// wb_fwd_merge: per-lane youngest-first merge of pending writes for one register.
module wb_fwd_merge
    import nqcpu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int DEPTH  = 4,
    localparam int LANES = lanes_of(DATA_W),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic [PW-1:0]     i_rd_ptr,
    input  logic [PW:0]       i_count,
    input  logic [REG_AW-1:0] i_fwd_reg,
    input  logic [REG_AW-1:0] i_reg [DEPTH],
    input  logic [DATA_W-1:0] i_data [DEPTH],
    input  logic [LANES-1:0]  i_be [DEPTH],
    output logic [LANES-1:0]  o_be,
    output logic [DATA_W-1:0] o_data
);
    logic [PW-1:0] w_idx;

    // walk oldest to youngest so the youngest hit overwrites each lane
    always_comb begin
        o_be   = '0;
        o_data = '0;
        w_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = i_rd_ptr + PW'(k);
            if (k < int'(i_count) && i_reg[w_idx] == i_fwd_reg) begin
                for (int l = 0; l < LANES; l++) begin
                    if (i_be[w_idx][l]) begin
                        o_be[l]          = 1'b1;
                        o_data[l*8 +: 8] = i_data[w_idx][l*8 +: 8];
                    end
                end
            end
        end
    end
endmodule

// File: rtl/regwrite_buffer.sv
// regwrite_buffer: in-order retire FIFO feeding the register file, with PC
// redirect pulse and forwarding of pending writes.
module regwrite_buffer
    import nqcpu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int DEPTH  = 4,
    localparam int LANES = lanes_of(DATA_W),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_reg_dest,
    input  logic [DATA_W-1:0] in_data,
    input  logic [LANES-1:0]  in_be,
    input  logic              in_setpc,
    output logic              rf_we,
    output logic [LANES-1:0]  rf_be,
    output logic [REG_AW-1:0] rf_reg_dest,
    output logic [DATA_W-1:0] rf_data,
    input  logic              rf_ready,
    output logic              setpc_o,
    output logic [DATA_W-1:0] setpc_value_o,
    input  logic [REG_AW-1:0] fwd_reg,
    output logic [LANES-1:0]  fwd_be,
    output logic [DATA_W-1:0] fwd_data,
    output logic [PW:0]       count
);
    logic [REG_AW-1:0] r_reg  [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [LANES-1:0]  r_be   [DEPTH];
    logic [PW-1:0]     r_wr, r_rd;
    logic [PW:0]       r_count;
    logic              r_setpc;
    logic [DATA_W-1:0] r_setpc_val;
    logic              w_empty, w_acc, w_enq, w_deq;

    assign w_empty       = r_count == '0;
    assign in_ready      = r_count != (PW+1)'(DEPTH);
    assign w_acc         = in_valid & in_ready;
    assign w_enq         = w_acc & |in_be;
    assign w_deq         = !w_empty & rf_ready;
    assign rf_we         = !w_empty;
    assign rf_be         = w_empty ? '0 : r_be[r_rd];
    assign rf_reg_dest   = r_reg[r_rd];
    assign rf_data       = r_data[r_rd];
    assign setpc_o       = r_setpc;
    assign setpc_value_o = r_setpc_val;
    assign count         = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr        <= '0;
            r_rd        <= '0;
            r_count     <= '0;
            r_setpc     <= 1'b0;
            r_setpc_val <= '0;
        end else begin
            r_wr        <= r_wr + PW'(w_enq);
            r_rd        <= r_rd + PW'(w_deq);
            r_count     <= r_count + (PW+1)'(w_enq) - (PW+1)'(w_deq);
            r_setpc     <= w_acc & in_setpc;
            r_setpc_val <= (w_acc & in_setpc) ? in_data : r_setpc_val;
        end
    end

    // payload needs no reset: occupancy alone qualifies every entry
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_reg[r_wr]  <= in_reg_dest;
            r_data[r_wr] <= in_data;
            r_be[r_wr]   <= in_be;
        end
    end

    wb_fwd_merge #(.DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH)) u_fwd (
        .i_rd_ptr (r_rd),
        .i_count  (r_count),
        .i_fwd_reg(fwd_reg),
        .i_reg    (r_reg),
        .i_data   (r_data),
        .i_be     (r_be),
        .o_be     (fwd_be),
        .o_data   (fwd_data)
    );
endmodule

// File: tb/tb_regwrite_buffer.sv
// tb_regwrite_buffer: directed checks of the default and a wide/deep configuration.
module tb_regwrite_buffer;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    logic        a_in_valid, a_in_ready, a_in_setpc, a_rf_we, a_rf_ready, a_setpc_o;
    logic [3:0]  a_in_reg_dest, a_rf_reg_dest, a_fwd_reg;
    logic [15:0] a_in_data, a_rf_data, a_setpc_value_o, a_fwd_data;
    logic [1:0]  a_in_be, a_rf_be, a_fwd_be;
    logic [2:0]  a_count;

    logic        b_in_valid, b_in_ready, b_in_setpc, b_rf_we, b_rf_ready, b_setpc_o;
    logic [3:0]  b_in_reg_dest, b_rf_reg_dest, b_fwd_reg;
    logic [31:0] b_in_data, b_rf_data, b_setpc_value_o, b_fwd_data;
    logic [3:0]  b_in_be, b_rf_be, b_fwd_be;
    logic [3:0]  b_count;

    regwrite_buffer u_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_reg_dest(a_in_reg_dest), .in_data(a_in_data), .in_be(a_in_be),
        .in_setpc(a_in_setpc), .rf_we(a_rf_we), .rf_be(a_rf_be),
        .rf_reg_dest(a_rf_reg_dest), .rf_data(a_rf_data), .rf_ready(a_rf_ready),
        .setpc_o(a_setpc_o), .setpc_value_o(a_setpc_value_o), .fwd_reg(a_fwd_reg),
        .fwd_be(a_fwd_be), .fwd_data(a_fwd_data), .count(a_count)
    );

    regwrite_buffer #(.DATA_W(32), .REG_AW(4), .DEPTH(8)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_reg_dest(b_in_reg_dest), .in_data(b_in_data), .in_be(b_in_be),
        .in_setpc(b_in_setpc), .rf_we(b_rf_we), .rf_be(b_rf_be),
        .rf_reg_dest(b_rf_reg_dest), .rf_data(b_rf_data), .rf_ready(b_rf_ready),
        .setpc_o(b_setpc_o), .setpc_value_o(b_setpc_value_o), .fwd_reg(b_fwd_reg),
        .fwd_be(b_fwd_be), .fwd_data(b_fwd_data), .count(b_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic a_drive(input logic v, input logic [3:0] r, input logic [15:0] d,
                           input logic [1:0] be, input logic sp);
        a_in_valid = v; a_in_reg_dest = r; a_in_data = d; a_in_be = be; a_in_setpc = sp;
    endtask

    function automatic logic [31:0] wd(input int i);
        return 32'hC0DE0000 + 32'(i) * 32'h00010101;
    endfunction

    function automatic logic [3:0] wbe(input int i);
        return (i % 3 == 0) ? 4'b0100 : 4'b1111;
    endfunction

    logic [31:0] sb_d [$];
    logic [3:0]  sb_be [$];
    logic [3:0]  sb_r [$];

    initial begin
        rst = 1'b1;
        a_drive(0, 0, 0, 0, 0);
        a_rf_ready = 0; a_fwd_reg = 0;
        b_in_valid = 0; b_in_reg_dest = 0; b_in_data = 0; b_in_be = 0; b_in_setpc = 0;
        b_rf_ready = 0; b_fwd_reg = 0;
        #12 rst = 1'b0;
        tick();
        chk("rst_count", 32'(a_count), 0);
        chk("rst_rf_we", 32'(a_rf_we), 0);
        chk("rst_rf_be", 32'(a_rf_be), 0);
        chk("rst_setpc", 32'(a_setpc_o), 0);
        chk("rst_setpc_val", 32'(a_setpc_value_o), 0);
        chk("rst_in_ready", 32'(a_in_ready), 1);
        chk("rst_b_ready", 32'(b_in_ready), 1);
        chk("rst_b_setpc", {31'd0, b_setpc_o} | b_setpc_value_o, 0);

        a_rf_ready = 1;
        a_drive(1, 3, 16'hBEEF, 2'b11, 0);
        tick();
        a_drive(0, 0, 0, 0, 0);
        chk("single_we", 32'(a_rf_we), 1);
        chk("single_dest", 32'(a_rf_reg_dest), 3);
        chk("single_data", 32'(a_rf_data), 32'hBEEF);
        chk("single_be", 32'(a_rf_be), 3);
        chk("single_count", 32'(a_count), 1);
        tick();
        chk("single_retired", 32'(a_count), 0);
        chk("single_we_off", 32'(a_rf_we), 0);
        chk("single_be_off", 32'(a_rf_be), 0);

        a_drive(1, 0, 0, 2'b00, 0);
        tick();
        a_drive(0, 0, 0, 0, 0);
        chk("noop_count", 32'(a_count), 0);
        chk("noop_setpc", 32'(a_setpc_o), 0);

        a_rf_ready = 0;
        for (int i = 0; i < 5; i++) begin
            a_drive(1, 4'(i + 1), 16'h1000 + 16'(i), 2'b11, 0);
            chk("fill_ready", 32'(a_in_ready), (i < 4) ? 1 : 0);
            tick();
        end
        chk("full_count", 32'(a_count), 4);
        chk("full_ready", 32'(a_in_ready), 0);
        a_rf_ready = 1;
        #1;
        chk("full_ready_no_comb", 32'(a_in_ready), 0);
        chk("drain_head0", 32'(a_rf_data), 32'h1000);
        chk("drain_dest0", 32'(a_rf_reg_dest), 1);
        tick();
        chk("drain_count1", 32'(a_count), 3);
        chk("drain_reopen", 32'(a_in_ready), 1);
        chk("drain_head1", 32'(a_rf_data), 32'h1001);
        tick();
        a_drive(0, 0, 0, 0, 0);
        chk("drain_enq_deq", 32'(a_count), 3);
        for (int i = 2; i < 5; i++) begin
            chk("drain_order", 32'(a_rf_data), 32'h1000 + 32'(i));
            tick();
        end
        chk("drain_empty", 32'(a_count), 0);

        a_rf_ready = 0;
        a_drive(1, 5, 16'h0011, 2'b01, 0); tick();
        a_drive(1, 5, 16'h2200, 2'b10, 0); tick();
        a_drive(1, 5, 16'h0033, 2'b01, 0); tick();
        a_drive(0, 0, 0, 0, 0);
        a_fwd_reg = 5;
        #1;
        chk("fwd_be", 32'(a_fwd_be), 2'b11);
        chk("fwd_data", 32'(a_fwd_data), 32'h2233);
        a_fwd_reg = 6;
        #1;
        chk("fwd_miss_be", 32'(a_fwd_be), 0);
        chk("fwd_miss_data", 32'(a_fwd_data), 0);
        chk("fwd_count", 32'(a_count), 3);

        rst = 1'b1;
        #1;
        chk("arst_count", 32'(a_count), 0);
        chk("arst_we", 32'(a_rf_we), 0);
        chk("arst_setpc", 32'(a_setpc_o), 0);
        chk("arst_ready", 32'(a_in_ready), 1);
        rst = 1'b0;
        tick();

        a_drive(1, 1, 16'h0A0A, 2'b11, 0); tick();
        a_drive(1, 2, 16'h0B0B, 2'b11, 0); tick();
        a_drive(1, 15, 16'h0400, 2'b11, 1); tick();
        a_drive(0, 0, 0, 0, 0);
        chk("redir_pulse", 32'(a_setpc_o), 1);
        chk("redir_value", 32'(a_setpc_value_o), 32'h0400);
        chk("redir_count", 32'(a_count), 3);
        tick();
        chk("redir_one_cycle", 32'(a_setpc_o), 0);
        chk("redir_hold", 32'(a_setpc_value_o), 32'h0400);
        a_drive(1, 7, 16'h0800, 2'b00, 1); tick();
        a_drive(0, 0, 0, 0, 0);
        chk("redir_only_pulse", 32'(a_setpc_o), 1);
        chk("redir_only_value", 32'(a_setpc_value_o), 32'h0800);
        chk("redir_only_count", 32'(a_count), 3);
        a_rf_ready = 1;
        #1;
        chk("link_first", 32'(a_rf_reg_dest), 1);
        tick();
        chk("link_second", 32'(a_rf_reg_dest), 2);
        tick();
        chk("link_third_dest", 32'(a_rf_reg_dest), 15);
        chk("link_third_data", 32'(a_rf_data), 32'h0400);
        tick();
        chk("link_empty", 32'(a_count), 0);

        for (int i = 0; i < 3; i++) begin
            b_in_valid = 1; b_in_reg_dest = 4'(i); b_in_data = wd(i); b_in_be = wbe(i);
            sb_d.push_back(wd(i)); sb_be.push_back(wbe(i)); sb_r.push_back(4'(i));
            tick();
        end
        b_rf_ready = 1;
        for (int i = 3; i < 23; i++) begin
            b_in_reg_dest = 4'(i); b_in_data = wd(i); b_in_be = wbe(i);
            #1;
            chk("wide_data", b_rf_data, sb_d[0]);
            chk("wide_be", 32'(b_rf_be), 32'(sb_be[0]));
            chk("wide_count", 32'(b_count), 3);
            tick();
            sb_d.push_back(wd(i)); sb_be.push_back(wbe(i)); sb_r.push_back(4'(i));
            void'(sb_d.pop_front()); void'(sb_be.pop_front()); void'(sb_r.pop_front());
        end
        b_in_valid = 0;
        for (int i = 0; i < 3; i++) begin
            chk("wide_tail_dest", 32'(b_rf_reg_dest), 32'(sb_r[0]));
            chk("wide_tail_data", b_rf_data, sb_d[0]);
            chk("wide_tail_we", 32'(b_rf_we), 1);
            tick();
            void'(sb_d.pop_front()); void'(sb_be.pop_front()); void'(sb_r.pop_front());
        end
        chk("wide_empty", 32'(b_count), 0);
        b_rf_ready = 0;
        b_in_valid = 1; b_in_reg_dest = 9; b_in_data = 32'hDDCCBBAA; b_in_be = 4'b0100;
        tick();
        b_in_valid = 0;
        b_fwd_reg = 9;
        #1;
        chk("wide_lane2_be", 32'(b_rf_be), 32'b0100);
        chk("wide_fwd_be", 32'(b_fwd_be), 32'b0100);
        chk("wide_fwd_data", b_fwd_data, 32'h00CC0000);
        chk("wide_setpc_idle", 32'(b_setpc_o), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
